// File: rtl/layernorm_pkg.sv
// Shared types and constants for the LayerNorm normalize stage.
package layernorm_pkg;

  localparam int DW          = 16;
  localparam int FRAC        = 8;
  localparam int SQRT_ITERS  = 12;
  localparam int RECIP_ITERS = 25;

  typedef enum logic [2:0] {
    IDLE,
    SQRT,
    RECIP,
    MUL,
    DONE
  } state_t;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sh0000_7fff)
      return 16'sh7fff;
    else if (v < -32'sh0000_8000)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/ln_isqrt_iter.sv
// Restoring digit-by-digit integer square root, two radicand bits per cycle.
// root holds floor(sqrt(radicand)) from the end of the run until the next start.
module ln_isqrt_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] radicand,
  output logic        done,
  output logic [11:0] root
);
  import layernorm_pkg::*;

  logic [23:0] rad_reg;
  logic [13:0] rem_reg;
  logic [11:0] root_reg;
  logic [3:0]  cnt_reg;
  logic        busy_reg;

  logic [15:0] rem_shift;
  logic [15:0] trial;
  logic [15:0] rem_diff;
  logic        ge;

  always_comb begin
    rem_shift = {rem_reg, rad_reg[23:22]};
    trial     = {2'b00, root_reg, 2'b01};
    rem_diff  = rem_shift - trial;
    ge        = (rem_shift >= trial);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad_reg  <= '0;
      rem_reg  <= '0;
      root_reg <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start) begin
      rad_reg  <= radicand;
      rem_reg  <= '0;
      root_reg <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      rad_reg  <= {rad_reg[21:0], 2'b00};
      rem_reg  <= ge ? 14'(rem_diff) : 14'(rem_shift);
      root_reg <= {root_reg[10:0], ge};
      cnt_reg  <= cnt_reg + 4'd1;
      if (cnt_reg == 4'(SQRT_ITERS - 1))
        busy_reg <= 1'b0;
    end
  end

  // High during the final iteration so the caller can move on at the same edge.
  assign done = busy_reg && (cnt_reg == 4'(SQRT_ITERS - 1));
  assign root = root_reg;

endmodule

// File: rtl/layernorm_normalize.sv
// LayerNorm normalize: std = sqrt(var + EPS), inv = 2^24 / std, then
// y[i] = (x[i] - mean) * inv >> 16, one element per cycle, valid/ready out.
module layernorm_normalize #(
  parameter int N   = 4,
  parameter int DW  = 16,
  parameter int EPS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x [N],
  input  logic signed [DW-1:0] mean,
  input  logic signed [DW-1:0] variance,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] y [N],
  output logic        [DW-1:0] std_out
);
  import layernorm_pkg::*;

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t              state_reg;
  logic                in_ready_reg;
  logic                out_valid_reg;
  logic signed [DW-1:0] x_reg [N];
  logic signed [DW-1:0] mean_reg;
  logic signed [DW-1:0] y_reg [N];
  logic        [DW-1:0] std_reg;
  logic [IW-1:0]       idx_reg;
  logic [4:0]          rcnt_reg;
  logic [11:0]         rrem_reg;
  logic [20:0]         inv_reg;

  logic                accept;
  logic [15:0]         var_clamp;
  logic [15:0]         v_sum;
  logic [23:0]         radicand;
  logic                sq_done;
  logic [11:0]         sq_root;

  logic [12:0]         rrem_shift;
  logic [12:0]         rrem_diff;
  logic                rge;

  logic signed [DW-1:0] x_sel;
  logic signed [16:0]  d;
  logic signed [38:0]  p;
  logic signed [22:0]  q;
  logic signed [15:0]  y_calc;

  assign accept = in_valid && in_ready_reg;

  // Negative variance is meaningless; clamp to zero before adding EPS.
  always_comb begin
    var_clamp = variance[DW-1] ? 16'd0 : 16'(variance);
    v_sum     = var_clamp + 16'(EPS);
    radicand  = {v_sum, 8'h00};
  end

  ln_isqrt_iter u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .radicand (radicand),
    .done     (sq_done),
    .root     (sq_root)
  );

  // Long division of 2^24 by std: the dividend has a single set bit at the top.
  always_comb begin
    rrem_shift = {rrem_reg, (rcnt_reg == 5'd0)};
    rrem_diff  = rrem_shift - {1'b0, sq_root};
    rge        = (rrem_shift >= {1'b0, sq_root});
  end

  always_comb begin
    x_sel  = x_reg[idx_reg];
    d      = $signed({x_sel[DW-1], x_sel}) - $signed({mean_reg[DW-1], mean_reg});
    p      = d * $signed({1'b0, inv_reg});
    q      = 23'(p >>> 16);
    y_calc = sat16({{9{q[22]}}, q});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      mean_reg      <= '0;
      std_reg       <= '0;
      idx_reg       <= '0;
      rcnt_reg      <= '0;
      rrem_reg      <= '0;
      inv_reg       <= '0;
      for (int i = 0; i < N; i++) begin
        x_reg[i] <= '0;
        y_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg    <= SQRT;
            in_ready_reg <= 1'b0;
            mean_reg     <= mean;
            rcnt_reg     <= '0;
            rrem_reg     <= '0;
            inv_reg      <= '0;
            for (int i = 0; i < N; i++)
              x_reg[i] <= x[i];
          end
        end
        SQRT: begin
          if (sq_done)
            state_reg <= RECIP;
        end
        RECIP: begin
          rrem_reg <= rge ? 12'(rrem_diff) : 12'(rrem_shift);
          inv_reg  <= {inv_reg[19:0], rge};
          rcnt_reg <= rcnt_reg + 5'd1;
          if (rcnt_reg == 5'(RECIP_ITERS - 1)) begin
            state_reg <= MUL;
            idx_reg   <= '0;
          end
        end
        MUL: begin
          y_reg[idx_reg] <= y_calc;
          idx_reg        <= idx_reg + 1'b1;
          if (idx_reg == IW'(N - 1)) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            std_reg       <= DW'(sq_root);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_y
      assign y[gi] = y_reg[gi];
    end
  endgenerate

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign std_out   = std_reg;

endmodule

// File: tb/tb_layernorm_normalize.sv
// Directed bench for layernorm_normalize with hand-computed expected vectors.
module tb_layernorm_normalize;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] x [N];
  logic signed [15:0] mean = '0;
  logic signed [15:0] variance = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] y [N];
  logic        [15:0] std_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  layernorm_normalize #(.N(N), .DW(16), .EPS(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .mean      (mean),
    .variance  (variance),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .std_out   (std_out)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input int e0, input int e1,
                           input int e2, input int e3, input int estd);
    int ey [N];
    ey[0] = e0; ey[1] = e1; ey[2] = e2; ey[3] = e3;
    for (int i = 0; i < N; i++)
      chk($sformatf("%s y[%0d]", tag, i), int'($signed(y[i])), ey[i]);
    chk({tag, " std_out"}, int'(std_out), estd);
  endtask

  // Present a vector at a negedge, let it be accepted, then scramble the bus.
  task automatic accept_vec(input string tag, input int x0, input int x1, input int x2,
                            input int x3, input int m, input int v);
    @(negedge clk);
    chk({tag, " in_ready before accept"}, int'(in_ready), 1);
    x[0] = 16'(x0); x[1] = 16'(x1); x[2] = 16'(x2); x[3] = 16'(x3);
    mean = 16'(m); variance = 16'(v);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) x[i] = 16'sh5a5a;
    mean = 16'sh1234;
    variance = 16'sh0777;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid after handshake"}, int'(out_valid), 0);
    chk({tag, " in_ready after handshake"}, int'(in_ready), 1);
  endtask

  task automatic run_vec(input string tag, input int x0, input int x1, input int x2,
                         input int x3, input int m, input int v, input int e0,
                         input int e1, input int e2, input int e3, input int estd);
    int lat;
    accept_vec(tag, x0, x1, x2, x3, m, v);
    wait_out(lat);
    chk({tag, " latency"}, lat, 41);
    check_out(tag, e0, e1, e2, e3, estd);
    $display("%s: std_out=%0d y=%0d %0d %0d %0d latency=%0d", tag, std_out,
             $signed(y[0]), $signed(y[1]), $signed(y[2]), $signed(y[3]), lat);
    release_out(tag);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < N; i++) x[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    check_out("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    run_vec("basic", 256, 512, 768, 1024, 640, 320, -344, -115, 114, 343, 286);
    run_vec("unit_std", 100, -100, 0, 300, 0, 256, 100, -100, 0, 300, 256);
    run_vec("var_zero", 16'h0500, 16'h0500, 16'h0500, 16'h0500, 16'h0500, 0, 0, 0, 0, 0, 16);
    run_vec("var_neg", 16'h0500, 16'h0500, 16'h0500, 16'h0500, 16'h0500, 16'hFF00, 0, 0, 0, 0, 16);
    run_vec("sat_pos", 32767, -32768, -32768, 0, -32768, 0, 32767, 0, 0, 32767, 16);
    run_vec("sat_neg", 32767, -32768, 32767, 32767, 32767, 0, 0, -32768, 0, 0, 16);

    // Backpressure: hold out_ready low while poking in_valid with other data.
    accept_vec("bp", 256, 512, 768, 1024, 640, 320);
    wait_out(lat);
    chk("bp latency", lat, 41);
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      x[0] = 16'(c * 100);
      mean = 16'(-c);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp c%0d out_valid", c), int'(out_valid), 1);
      chk($sformatf("bp c%0d in_ready", c), int'(in_ready), 0);
      chk($sformatf("bp c%0d y[0]", c), int'($signed(y[0])), -344);
      chk($sformatf("bp c%0d std_out", c), int'(std_out), 286);
    end
    in_valid = 1'b0;
    check_out("bp held", -344, -115, 114, 343, 286);
    $display("bp: held 10 cycles std_out=%0d y0=%0d", std_out, $signed(y[0]));
    release_out("bp");
    repeat (3) @(negedge clk);
    chk("bp no spurious out_valid", int'(out_valid), 0);
    chk("bp still idle", int'(in_ready), 1);

    // Reset in the middle of the reciprocal phase aborts the vector.
    accept_vec("rst_mid", 256, 512, 768, 1024, 640, 320);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid in_ready", int'(in_ready), 1);
    chk("rst_mid out_valid", int'(out_valid), 0);
    check_out("rst_mid", 0, 0, 0, 0, 0);
    $display("rst_mid: reset asserted during RECIP, outputs cleared");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid no output", int'(out_valid), 0);

    run_vec("after_rst", 256, 512, 768, 1024, 640, 320, -344, -115, 114, 343, 286);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/layernorm_normalize.md
Name: layernorm_normalize

Overview:
- Downstream neighbour of the combinational variance stage in the LayerNorm datapath.
- Latches one N-element Q8.8 vector together with its mean and variance.
- Computes std = sqrt(var + EPS) sequentially, then the reciprocal 1/std, then y[i] = (x[i] - mean) * (1/std) one element per cycle.
- Presents the normalized vector with a valid/ready handshake to the gamma/beta affine stage.

Parameters:
- N, 4, vector length (≥1)
- DW, 16, data width, signed Q8.8
- EPS, 1, epsilon in raw Q8.8 LSBs (≥1, so std is never zero)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input vector, mean and variance valid
- in_ready  out  1  block can accept; high only in IDLE
- x  in  DW×N (unpacked [N])  signed Q8.8 elements
- mean  in  DW  signed Q8.8 mean
- variance  in  DW  signed Q8.8 variance; negative values are clamped to 0
- out_valid  out  1  y and std_out valid
- out_ready  in  1  consumer accepts
- y  out  DW×N (unpacked [N])  signed Q8.8 normalized elements
- std_out  out  DW  unsigned Q8.8 std, zero-extended

Behaviour:
- Reset: asynchronous; state=IDLE, in_ready=1, out_valid=0, y all 0, std_out=0, all internal registers 0. Reset asserted mid-operation aborts the vector; no output is produced for it.
- States: IDLE → SQRT → RECIP → MUL → DONE → IDLE.
- IDLE:
  - On the edge where in_valid && in_ready, capture x, mean and V = max(variance, 0) + EPS (unsigned, 16 bits; no overflow since variance ≤ 0x7FFF).
  - Move to SQRT.
- SQRT:
  - 12 cycles of restoring digit-by-digit integer square root of R = V << 8 (24 bits), producing s = floor(sqrt(R)).
  - s is std in Q8.8; 12 bits; s ≥ 16.
- RECIP:
  - 25 cycles of restoring unsigned division computing inv = floor(2^24 / s).
  - inv is Q.16, at most 2^20, 21 bits.
- MUL:
  - N cycles, element i on cycle i.
  - d = x[i] - mean, 17-bit signed.
  - p = d * inv, signed, 38 bits.
  - q = p >>> 16 (arithmetic shift, rounds toward −∞).
  - y[i] = q saturated to [-32768, 32767].
- Latency: out_valid rises exactly N+37 cycles after the accepting edge (41 for N=4).
- DONE:
  - out_valid=1; y and std_out={4'b0,s} are held stable.
  - On out_valid && out_ready, go to IDLE; out_valid drops and in_ready rises on the next cycle.
  - No same-cycle re-accept.
- in_valid outside IDLE is ignored; the input bus is only sampled at acceptance.
- Output registers keep their last value after the handshake until overwritten by the next MUL.

Decomposition:
- Shared package layernorm_pkg holds:
  - DW and FRAC=8
  - state enum {IDLE, SQRT, RECIP, MUL, DONE}
  - iteration constants SQRT_ITERS=12, RECIP_ITERS=25
  - a sat16 function
- One sub-module: ln_isqrt_iter, a start/done sequential digit-by-digit square root instantiated for the SQRT phase.
- Reciprocal division and MUL logic stay inline.

Test Plan:
- x={256,512,768,1024}, mean=640, variance=320 → std_out=286, y={-344,-115,114,343}, out_valid at accept+41.
- All x=0x0500, mean=0x0500, variance=0 → std_out=16, y all 0.
- variance=0xFF00 (negative), other inputs as in the previous case → identical result: std_out=16, y all 0.
- Saturation, variance=0:
  - x[0]=32767, mean=-32768 → y[0]=32767.
  - x[1]=-32768, mean=32767 → y[1]=-32768.
- Backpressure: out_ready=0 for 10 cycles after out_valid → y and std_out stable, in_ready=0, in_valid pulses ignored. Raising out_ready then gives out_valid=0 and in_ready=1 one cycle later.
- Reset pulse during RECIP (cycle 20) → all outputs 0 and in_ready=1 immediately. The next accepted vector completes with correct values and nominal latency.
